// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings for the multicycle control unit
// Contents: state codes, opcode/funct constants, ALUControl codes,
// ALUOp, ALUSrcB and PCSrc encodings.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// rtl/multicycle_control_fsm_alu_decoder.sv - ALUOp/funct to ALUControl decoder
// Ports: alu_op (add / sub / use funct), funct (instr[5:0]),
// alu_control (3-bit ALU operation), illegal_funct (unsupported funct while alu_op selects funct).
module alu_decoder
    import multicycle_control_fsm_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  alu_op_t              alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [2:0]           alu_control,
    output logic                 illegal_funct
);

    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    // Unknown funct still executes as an add so the instruction completes.
                    default:   illegal_funct = 1'b1;
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS-subset main control FSM
// Ports: CLK, RST (async active-low); Opcode, Funct from IR; Zero from ALU;
// PCEn/PCSrc to PC stage; IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
// ALUSrcA, ALUSrcB, ALUControl to datapath; IllegalOp pulse; State debug view.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int STATE_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OP_W-1:0]     Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    output logic                PCEn,
    output logic [1:0]          PCSrc,
    output logic                IorD,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUControl,
    output logic                IllegalOp,
    output logic [STATE_W-1:0]  State
);

    state_t     state_q;
    alu_op_t    alu_op;
    logic       pc_write;
    logic       branch;
    logic       alu_valid;
    logic       illegal_opcode;
    logic       illegal_funct;
    logic [2:0] alu_control_dec;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_EXECUTE:  state_q <= S_ALUWB;
                S_ADDIEX:   state_q <= S_ADDIWB;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write       = 1'b0;
        branch         = 1'b0;
        PCSrc          = PCSRC_ALU;
        IorD           = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        RegDst         = 1'b0;
        MemtoReg       = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = SRCB_B;
        alu_op         = ALUOP_ADD;
        alu_valid      = 1'b1;
        illegal_opcode = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = SRCB_FOUR;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                ALUSrcB = SRCB_IMM_SH;
                illegal_opcode = !((Opcode == OP_LW) || (Opcode == OP_SW) ||
                                   (Opcode == OP_RTYPE) || (Opcode == OP_BEQ) ||
                                   (Opcode == OP_ADDI) || (Opcode == OP_J));
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            // Unused codes drive every output low, including ALUControl.
            default:    alu_valid = 1'b0;
        endcase
    end

    alu_decoder #(
        .FUNCT_W(FUNCT_W)
    ) u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (alu_control_dec),
        .illegal_funct (illegal_funct)
    );

    assign ALUControl = alu_valid ? alu_control_dec : 3'b000;
    // illegal_funct can only rise in EXECUTE since only that state selects funct decode.
    assign IllegalOp  = illegal_opcode | illegal_funct;
    assign PCEn       = pc_write | (branch & Zero);
    assign State      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       CLK;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       IllegalOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm dut (
        .CLK        (CLK),
        .RST        (RST),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .Zero       (Zero),
        .PCEn       (PCEn),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp),
        .State      (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bundle order: PCEn PCSrc IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUControl IllegalOp
    logic [15:0] outs;
    assign outs = {PCEn, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ALUControl, IllegalOp};

    localparam logic [15:0] V_FETCH    = 16'b1_00_0_0_1_0_0_0_0_01_010_0;
    localparam logic [15:0] V_DECODE   = 16'b0_00_0_0_0_0_0_0_0_11_010_0;
    localparam logic [15:0] V_DEC_ILL  = 16'b0_00_0_0_0_0_0_0_0_11_010_1;
    localparam logic [15:0] V_MEMADR   = 16'b0_00_0_0_0_0_0_0_1_10_010_0;
    localparam logic [15:0] V_MEMREAD  = 16'b0_00_1_0_0_0_0_0_0_00_010_0;
    localparam logic [15:0] V_MEMWB    = 16'b0_00_0_0_0_0_1_1_0_00_010_0;
    localparam logic [15:0] V_MEMWRITE = 16'b0_00_1_1_0_0_0_0_0_00_010_0;
    localparam logic [15:0] V_EX_SUB   = 16'b0_00_0_0_0_0_0_0_1_00_110_0;
    localparam logic [15:0] V_EX_SLT   = 16'b0_00_0_0_0_0_0_0_1_00_111_0;
    localparam logic [15:0] V_EX_ILL   = 16'b0_00_0_0_0_0_0_0_1_00_010_1;
    localparam logic [15:0] V_ALUWB    = 16'b0_00_0_0_0_1_0_1_0_00_010_0;
    localparam logic [15:0] V_BR_TAKEN = 16'b1_01_0_0_0_0_0_0_1_00_110_0;
    localparam logic [15:0] V_BR_NOT   = 16'b0_01_0_0_0_0_0_0_1_00_110_0;
    localparam logic [15:0] V_ADDIEX   = 16'b0_00_0_0_0_0_0_0_1_10_010_0;
    localparam logic [15:0] V_ADDIWB   = 16'b0_00_0_0_0_0_0_1_0_00_010_0;
    localparam logic [15:0] V_JUMP     = 16'b1_10_0_0_0_0_0_0_0_00_010_0;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  exp_state;
        logic [15:0] exp_outs;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [3:0] st, input logic [15:0] o);
        vecs[i].opcode    = op;
        vecs[i].funct     = fn;
        vecs[i].zero      = z;
        vecs[i].exp_state = st;
        vecs[i].exp_outs  = o;
    endtask

    initial begin
        // lw, with a garbage opcode during FETCH and changes during MEMREAD/MEMWB that must be ignored
        set_vec(0,  6'b111111, 6'b000000, 1'b0, 4'd0,  V_FETCH);
        set_vec(1,  6'b100011, 6'b000000, 1'b0, 4'd1,  V_DECODE);
        set_vec(2,  6'b100011, 6'b000000, 1'b0, 4'd2,  V_MEMADR);
        set_vec(3,  6'b000100, 6'b000000, 1'b1, 4'd3,  V_MEMREAD);
        set_vec(4,  6'b000000, 6'b000000, 1'b1, 4'd4,  V_MEMWB);
        // sw
        set_vec(5,  6'b101011, 6'b000000, 1'b0, 4'd0,  V_FETCH);
        set_vec(6,  6'b101011, 6'b000000, 1'b0, 4'd1,  V_DECODE);
        set_vec(7,  6'b101011, 6'b000000, 1'b0, 4'd2,  V_MEMADR);
        set_vec(8,  6'b000000, 6'b000000, 1'b0, 4'd5,  V_MEMWRITE);
        // R-type sub; funct changed in ALUWB must not matter
        set_vec(9,  6'b000000, 6'b100010, 1'b0, 4'd0,  V_FETCH);
        set_vec(10, 6'b000000, 6'b100010, 1'b0, 4'd1,  V_DECODE);
        set_vec(11, 6'b000000, 6'b100010, 1'b0, 4'd6,  V_EX_SUB);
        set_vec(12, 6'b000000, 6'b000000, 1'b0, 4'd7,  V_ALUWB);
        // R-type slt
        set_vec(13, 6'b000000, 6'b101010, 1'b0, 4'd0,  V_FETCH);
        set_vec(14, 6'b000000, 6'b101010, 1'b0, 4'd1,  V_DECODE);
        set_vec(15, 6'b000000, 6'b101010, 1'b0, 4'd6,  V_EX_SLT);
        set_vec(16, 6'b000000, 6'b101010, 1'b0, 4'd7,  V_ALUWB);
        // beq taken
        set_vec(17, 6'b000100, 6'b000000, 1'b1, 4'd0,  V_FETCH);
        set_vec(18, 6'b000100, 6'b000000, 1'b1, 4'd1,  V_DECODE);
        set_vec(19, 6'b000100, 6'b000000, 1'b1, 4'd8,  V_BR_TAKEN);
        // beq not taken; Zero high outside BRANCH has no effect
        set_vec(20, 6'b000100, 6'b000000, 1'b1, 4'd0,  V_FETCH);
        set_vec(21, 6'b000100, 6'b000000, 1'b1, 4'd1,  V_DECODE);
        set_vec(22, 6'b000100, 6'b000000, 1'b0, 4'd8,  V_BR_NOT);
        // j
        set_vec(23, 6'b000010, 6'b000000, 1'b0, 4'd0,  V_FETCH);
        set_vec(24, 6'b000010, 6'b000000, 1'b0, 4'd1,  V_DECODE);
        set_vec(25, 6'b000010, 6'b000000, 1'b0, 4'd11, V_JUMP);
        // addi
        set_vec(26, 6'b001000, 6'b000000, 1'b0, 4'd0,  V_FETCH);
        set_vec(27, 6'b001000, 6'b000000, 1'b0, 4'd1,  V_DECODE);
        set_vec(28, 6'b001000, 6'b000000, 1'b0, 4'd9,  V_ADDIEX);
        set_vec(29, 6'b001000, 6'b000000, 1'b0, 4'd10, V_ADDIWB);
        // illegal opcode: pulse in DECODE then straight back to FETCH
        set_vec(30, 6'b111111, 6'b000000, 1'b0, 4'd0,  V_FETCH);
        set_vec(31, 6'b111111, 6'b000000, 1'b0, 4'd1,  V_DEC_ILL);
        set_vec(32, 6'b000000, 6'b000000, 1'b0, 4'd0,  V_FETCH);
        // illegal funct: pulse in EXECUTE, instruction still completes
        set_vec(33, 6'b000000, 6'b000000, 1'b0, 4'd1,  V_DECODE);
        set_vec(34, 6'b000000, 6'b000000, 1'b0, 4'd6,  V_EX_ILL);
        set_vec(35, 6'b000000, 6'b000000, 1'b0, 4'd7,  V_ALUWB);
        set_vec(36, 6'b000000, 6'b000000, 1'b0, 4'd0,  V_FETCH);

        RST    = 1'b0;
        Opcode = 6'b000000;
        Funct  = 6'b000000;
        Zero   = 1'b0;

        // Reset state
        @(negedge CLK);
        #1;
        check("reset_state", {12'd0, State}, 16'd0);
        check("reset_outs", outs, V_FETCH);

        // Run lw into MEMREAD, then assert reset mid-cycle
        @(posedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK); Opcode = 6'b100011;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("pre_abort_state", {12'd0, State}, 16'd3);
        #1 RST = 1'b0;
        #1;
        check("abort_state", {12'd0, State}, 16'd0);
        check("abort_outs", outs, V_FETCH);
        @(posedge CLK);
        #1;
        check("abort_hold_state", {12'd0, State}, 16'd0);
        check("abort_hold_outs", outs, V_FETCH);
        RST = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            Opcode = vecs[i].opcode;
            Funct  = vecs[i].funct;
            Zero   = vecs[i].zero;
            #1;
            check($sformatf("vec%0d_state", i), {12'd0, State}, {12'd0, vecs[i].exp_state});
            check($sformatf("vec%0d_outs", i), outs, vecs[i].exp_outs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
